// File: rtl/ddr_rx_gearbox_if.sv
// Stream bundle for ddr_rx_gearbox: DDR pad-side input and valid/ready word output.
interface ddr_rx_gearbox_if #(
  parameter int W = 8
) ();
  logic [W-1:0]   din;
  logic           din_en;
  logic [2*W-1:0] m_data;
  logic [1:0]     m_keep;
  logic           m_valid;
  logic           m_ready;

  modport master (
    input  din,
    input  din_en,
    input  m_ready,
    output m_data,
    output m_keep,
    output m_valid
  );

  modport slave (
    output din,
    output din_en,
    output m_ready,
    input  m_data,
    input  m_keep,
    input  m_valid
  );
endinterface

// File: rtl/ddr_rx_gearbox.sv
// DDR capture on both clk edges, rise/fall pairs packed into 2*W-bit words behind a FWFT FIFO.
// Define DDR_RX_OVF_CNT_EN to add the saturating dropped-pair counter port ovf_cnt.
module ddr_rx_gearbox #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int ORDER = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  ddr_rx_gearbox_if.master       bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  input  logic                   ovf_clr
`ifdef DDR_RX_OVF_CNT_EN
  ,
  output logic [15:0]            ovf_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = 2 * W + 2;
  localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0]  r_d_r;
  logic          r_en_r;
  logic [W-1:0]  f_d_r;
  logic          f_en_r;
  logic [W-1:0]  r_half_s;
  logic [W-1:0]  f_half_s;
  logic [1:0]    keep_s;
  logic [DW-1:0] pair_s;
  logic [DW-1:0] mem_r [DEPTH];
  logic [DW-1:0] head_r;
  logic [DW-1:0] head_nxt_s;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_nxt_s;
  logic [PW-1:0] rd_nxt_s;
  logic [PW-1:0] level_r;
  logic          valid_r;
  logic          ovf_r;
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          push_req_s;
  logic          push_s;
  logic          drop_s;

  // Rise-edge sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_r  <= {W{1'b0}};
      r_en_r <= 1'b0;
    end else begin
      r_d_r  <= bus.din;
      r_en_r <= bus.din_en;
    end
  end

  // Fall-edge sample
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      f_d_r  <= {W{1'b0}};
      f_en_r <= 1'b0;
    end else begin
      f_d_r  <= bus.din;
      f_en_r <= bus.din_en;
    end
  end

  // Pair assembly: disabled halves zeroed, keep stays in rise/fall naming regardless of ORDER
  always_comb begin
    r_half_s = r_en_r ? r_d_r : {W{1'b0}};
    f_half_s = f_en_r ? f_d_r : {W{1'b0}};
    keep_s   = {f_en_r, r_en_r};
    if (ORDER == 0) begin
      pair_s = {keep_s, f_half_s, r_half_s};
    end else begin
      pair_s = {keep_s, r_half_s, f_half_s};
    end
  end

  // FIFO control and next head; an empty FIFO bypasses the incoming pair straight to the head
  always_comb begin
    empty_s    = (wr_ptr_r == rd_ptr_r);
    full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s      = !empty_s && bus.m_ready;
    push_req_s = (keep_s != 2'b00);
    push_s     = push_req_s && (!full_s || pop_s);
    drop_s     = push_req_s && full_s && !pop_s;
    wr_nxt_s   = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
    rd_nxt_s   = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    if (rd_nxt_s != wr_ptr_r) begin
      head_nxt_s = mem_r[rd_nxt_s[AW-1:0]];
    end else if (push_s) begin
      head_nxt_s = pair_s;
    end else begin
      head_nxt_s = head_r;
    end
  end

  // FIFO storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= pair_s;
    end else begin
      mem_r <= mem_r;
    end
  end

  // Pointers, registered head/valid/level and sticky overflow (set beats clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      head_r   <= {DW{1'b0}};
      level_r  <= {PW{1'b0}};
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_nxt_s;
      rd_ptr_r <= rd_nxt_s;
      head_r   <= head_nxt_s;
      level_r  <= wr_nxt_s - rd_nxt_s;
      valid_r  <= (wr_nxt_s != rd_nxt_s);
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

`ifdef DDR_RX_OVF_CNT_EN
  logic [15:0] ovf_cnt_r;

  // Dropped-pair counter: clear beats increment, saturates at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_r <= 16'h0000;
    end else if (ovf_clr) begin
      ovf_cnt_r <= 16'h0000;
    end else if (drop_s && (ovf_cnt_r != 16'hFFFF)) begin
      ovf_cnt_r <= ovf_cnt_r + 16'h0001;
    end else begin
      ovf_cnt_r <= ovf_cnt_r;
    end
  end

  assign ovf_cnt = ovf_cnt_r;
`endif

  assign bus.m_data  = head_r[2*W-1:0];
  assign bus.m_keep  = head_r[DW-1:2*W];
  assign bus.m_valid = valid_r;
  assign level       = level_r;
  assign ovf         = ovf_r;
endmodule

// File: tb/tb_ddr_rx_gearbox.sv
// Bench for ddr_rx_gearbox: ORDER=0 and ORDER=1 instances share one stimulus stream.
module tb_ddr_rx_gearbox;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_en;
  logic       m_ready;
  logic       ovf_clr;
  logic [2:0] level0;
  logic [2:0] level1;
  logic       ovf0;
  logic       ovf1;
`ifdef DDR_RX_OVF_CNT_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  int n_pass  = 0;
  int n_total = 0;

  ddr_rx_gearbox_if #(.W(W)) bus0 ();
  ddr_rx_gearbox_if #(.W(W)) bus1 ();

  assign bus0.din     = din;
  assign bus0.din_en  = din_en;
  assign bus0.m_ready = m_ready;
  assign bus1.din     = din;
  assign bus1.din_en  = din_en;
  assign bus1.m_ready = m_ready;

  ddr_rx_gearbox #(.W(W), .DEPTH(DEPTH), .ORDER(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .level(level0), .ovf(ovf0), .ovf_clr(ovf_clr)
`ifdef DDR_RX_OVF_CNT_EN
    , .ovf_cnt(cnt0)
`endif
  );

  ddr_rx_gearbox #(.W(W), .DEPTH(DEPTH), .ORDER(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .level(level1), .ovf(ovf1), .ovf_clr(ovf_clr)
`ifdef DDR_RX_OVF_CNT_EN
    , .ovf_cnt(cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: queue of accepted pairs, stored by rise/fall sample
  typedef struct packed {
    logic [7:0] rd;
    logic       re;
    logic [7:0] fd;
    logic       fe;
  } pair_t;

  pair_t q[$];
  pair_t pend;
  pair_t last_head;
  logic  m_ovf;
  int    m_cnt;

  typedef struct packed {
    logic [7:0]  rd;
    logic        re;
    logic [7:0]  fd;
    logic        fe;
    logic        rdy;
    logic        clr;
    logic        valid;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  keep;
    logic [2:0]  lvl;
    logic        ovf;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [15:0] word_of(pair_t p, int order);
    if (order == 0) return {p.fd, p.rd};
    return {p.rd, p.fd};
  endfunction

  task automatic model_tick(input logic rdy, input logic clr);
    logic pop;
    logic drop;
    pop  = (q.size() > 0) && rdy;
    drop = 1'b0;
    if (pop) q.delete(0);
    if (pend.re || pend.fe) begin
      if (q.size() < DEPTH) q.push_back(pend);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (clr) m_cnt = 0;
    else if (drop && m_cnt < 65535) m_cnt++;
    if (q.size() > 0) last_head = q[0];
  endtask

  // One clock: rise sample for the coming posedge, fall sample for the following negedge
  task automatic step(input logic [7:0] rd, input logic re, input logic [7:0] fd, input logic fe,
                      input logic rdy, input logic clr);
    @(negedge clk);
    #1;
    din = rd; din_en = re; m_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    #1;
    din = fd; din_en = fe;
    model_tick(rdy, clr);
    pend.rd = re ? rd : 8'h00;
    pend.re = re;
    pend.fd = fe ? fd : 8'h00;
    pend.fe = fe;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid0"}, bus0.m_valid, q.size() > 0);
    chk({tag, "_valid1"}, bus1.m_valid, q.size() > 0);
    chk({tag, "_data0"}, bus0.m_data, word_of(last_head, 0));
    chk({tag, "_data1"}, bus1.m_data, word_of(last_head, 1));
    chk({tag, "_keep0"}, bus0.m_keep, {last_head.fe, last_head.re});
    chk({tag, "_keep1"}, bus1.m_keep, {last_head.fe, last_head.re});
    chk({tag, "_level0"}, level0, q.size());
    chk({tag, "_level1"}, level1, q.size());
    chk({tag, "_ovf0"}, ovf0, m_ovf);
    chk({tag, "_ovf1"}, ovf1, m_ovf);
`ifdef DDR_RX_OVF_CNT_EN
    chk({tag, "_cnt0"}, cnt0, m_cnt);
    chk({tag, "_cnt1"}, cnt1, m_cnt);
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid0"}, bus0.m_valid, 1'b0);
    chk({tag, "_valid1"}, bus1.m_valid, 1'b0);
    chk({tag, "_data0"}, bus0.m_data, 16'h0000);
    chk({tag, "_data1"}, bus1.m_data, 16'h0000);
    chk({tag, "_keep0"}, bus0.m_keep, 2'b00);
    chk({tag, "_level0"}, level0, 3'd0);
    chk({tag, "_level1"}, level1, 3'd0);
    chk({tag, "_ovf0"}, ovf0, 1'b0);
  endtask

  // Reset pulse between posedge and negedge; the coming negedge still captures the fall sample
  task automatic pulse_reset(input string tag);
    #1 rst = 1'b1;
    #1;
    check_zero(tag);
    rst = 1'b0;
    q.delete();
    last_head = '0;
    m_ovf     = 1'b0;
    m_cnt     = 0;
    pend.rd   = 8'h00;
    pend.re   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //              rd    re    fd    fe   rdy   clr | v     d0        d1        keep   lvl   ovf   cnt
    vecs[0]  = '{8'hA1, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 3'd0, 1'b0, 16'd0};
    vecs[1]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'hB2A1, 16'hA1B2, 2'b11, 3'd1, 1'b0, 16'd0};
    vecs[2]  = '{8'hC3, 1'b1, 8'hD4, 1'b0, 1'b1, 1'b0, 1'b0, 16'hB2A1, 16'hA1B2, 2'b11, 3'd0, 1'b0, 16'd0};
    vecs[3]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00C3, 16'hC300, 2'b01, 3'd1, 1'b0, 16'd0};
    vecs[4]  = '{8'h55, 1'b0, 8'hE5, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00C3, 16'hC300, 2'b01, 3'd1, 1'b0, 16'd0};
    vecs[5]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'hE500, 16'h00E5, 2'b10, 3'd1, 1'b0, 16'd0};
    vecs[6]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'hE500, 16'h00E5, 2'b10, 3'd0, 1'b0, 16'd0};
    vecs[7]  = '{8'h11, 1'b1, 8'h21, 1'b1, 1'b0, 1'b0, 1'b0, 16'hE500, 16'h00E5, 2'b10, 3'd0, 1'b0, 16'd0};
    vecs[8]  = '{8'h12, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 16'h2111, 16'h1121, 2'b11, 3'd1, 1'b0, 16'd0};
    vecs[9]  = '{8'h13, 1'b1, 8'h23, 1'b1, 1'b0, 1'b0, 1'b1, 16'h2111, 16'h1121, 2'b11, 3'd2, 1'b0, 16'd0};
    vecs[10] = '{8'h14, 1'b1, 8'h24, 1'b1, 1'b0, 1'b0, 1'b1, 16'h2111, 16'h1121, 2'b11, 3'd3, 1'b0, 16'd0};
    vecs[11] = '{8'h15, 1'b1, 8'h25, 1'b1, 1'b0, 1'b0, 1'b1, 16'h2111, 16'h1121, 2'b11, 3'd4, 1'b0, 16'd0};
    vecs[12] = '{8'h16, 1'b1, 8'h26, 1'b1, 1'b0, 1'b0, 1'b1, 16'h2111, 16'h1121, 2'b11, 3'd4, 1'b1, 16'd1};
    vecs[13] = '{8'h33, 1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1, 16'h2111, 16'h1121, 2'b11, 3'd4, 1'b1, 16'd2};
    vecs[14] = '{8'h55, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b1, 16'h2111, 16'h1121, 2'b11, 3'd4, 1'b1, 16'd0};
    vecs[15] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 16'h2212, 16'h1222, 2'b11, 3'd4, 1'b0, 16'd0};
    vecs[16] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h2313, 16'h1323, 2'b11, 3'd3, 1'b0, 16'd0};
    vecs[17] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h2414, 16'h1424, 2'b11, 3'd2, 1'b0, 16'd0};
    vecs[18] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h6655, 16'h5566, 2'b11, 3'd1, 1'b0, 16'd0};
    vecs[19] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h6655, 16'h5566, 2'b11, 3'd0, 1'b0, 16'd0};

    rst = 1'b1; din = 8'h00; din_en = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
    q.delete(); pend = '0; last_head = '0; m_ovf = 1'b0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    #1 rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].rd, vecs[i].re, vecs[i].fd, vecs[i].fe, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("v%0d_valid0", i), bus0.m_valid, vecs[i].valid);
      chk($sformatf("v%0d_valid1", i), bus1.m_valid, vecs[i].valid);
      chk($sformatf("v%0d_data0", i), bus0.m_data, vecs[i].d0);
      chk($sformatf("v%0d_data1", i), bus1.m_data, vecs[i].d1);
      chk($sformatf("v%0d_keep0", i), bus0.m_keep, vecs[i].keep);
      chk($sformatf("v%0d_keep1", i), bus1.m_keep, vecs[i].keep);
      chk($sformatf("v%0d_level0", i), level0, vecs[i].lvl);
      chk($sformatf("v%0d_level1", i), level1, vecs[i].lvl);
      chk($sformatf("v%0d_ovf0", i), ovf0, vecs[i].ovf);
      chk($sformatf("v%0d_ovf1", i), ovf1, vecs[i].ovf);
`ifdef DDR_RX_OVF_CNT_EN
      chk($sformatf("v%0d_cnt0", i), cnt0, vecs[i].cnt);
`endif
    end

    // Mid-burst reset with three words queued; first pair afterwards carries only the fall half
    step(8'h71, 1'b1, 8'h72, 1'b1, 1'b0, 1'b0);
    step(8'h73, 1'b1, 8'h74, 1'b1, 1'b0, 1'b0);
    step(8'h75, 1'b1, 8'h76, 1'b1, 1'b0, 1'b0);
    step(8'h77, 1'b1, 8'h78, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_level", level0, 3'd3);
    chk("pre_rst_head", bus0.m_data, 16'h7271);
    pulse_reset("midrst");
    step(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("post_rst_valid", bus0.m_valid, 1'b1);
    chk("post_rst_data0", bus0.m_data, 16'h7800);
    chk("post_rst_data1", bus1.m_data, 16'h0078);
    chk("post_rst_keep", bus0.m_keep, 2'b10);
    check_model("post_rst");
    step(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_model("post_rst_drain");

    // Randomised traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      step(8'($urandom), ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) < 4), ($urandom_range(0, 7) == 0));
      check_model($sformatf("rnd%0d", i));
      if (i == 200) begin
        pulse_reset("rnd_rst");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
